// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: latches floor requests, runs a SCAN sweep,
// times floor-to-floor travel and door dwell, and clears requests as they are served.
module elevator_request_scheduler #(
  parameter int FLOORS      = 5,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [FLOORS-1:0] buttons_i,
  output logic [2:0]        cur_floor_o,
  output logic              dir_up_o,
  output logic              moving_o,
  output logic              door_open_o,
  output logic [FLOORS-1:0] pending_o,
  output logic              served_o,
  output logic [2:0]        served_floor_o
);

  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MOVE_TC = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_TC = DW'(DOOR_CYCLES - 1);
  localparam logic [2:0]    TOP     = 3'(FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

  state_e            state_q;
  logic [2:0]        cur_floor_q;
  logic              dir_up_q;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [MW-1:0]     move_cnt_q;
  logic [DW-1:0]     door_cnt_q;
  logic              served_q;
  logic [2:0]        served_floor_q;

  function automatic logic any_above(input logic [FLOORS-1:0] pend, input logic [2:0] fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (pend[i] && (3'(i) > fl)) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] pend, input logic [2:0] fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (pend[i] && (3'(i) < fl)) r = 1'b1;
    return r;
  endfunction

  function automatic logic pend_at(input logic [FLOORS-1:0] pend, input logic [2:0] fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (3'(i) == fl) r = pend[i];
    return r;
  endfunction

  logic              dir_eff;
  logic              ahead_eff, behind_eff;
  logic [2:0]        next_floor;
  logic              at_cur, at_next, ahead_next;
  logic              up_any, dn_any;
  logic [FLOORS-1:0] clear_mask;

  always_comb begin
    // End floors force the preferred direction whenever the car leaves IDLE/DOOR.
    dir_eff = dir_up_q;
    if (cur_floor_q == 3'd0)     dir_eff = 1'b1;
    else if (cur_floor_q == TOP) dir_eff = 1'b0;

    up_any     = any_above(pending_q, cur_floor_q);
    dn_any     = any_below(pending_q, cur_floor_q);
    ahead_eff  = dir_eff ? up_any : dn_any;
    behind_eff = dir_eff ? dn_any : up_any;
    at_cur     = pend_at(pending_q, cur_floor_q);

    next_floor = dir_up_q ? (cur_floor_q + 3'd1) : (cur_floor_q - 3'd1);
    at_next    = pend_at(pending_q, next_floor);
    ahead_next = dir_up_q ? any_above(pending_q, next_floor) : any_below(pending_q, next_floor);

    clear_mask = '0;
    for (int i = 0; i < FLOORS; i++)
      clear_mask[i] = (3'(i) == cur_floor_q) &&
                      ((state_q == DOOR) || ((state_q == IDLE) && at_cur));
    pending_d = (pending_q | buttons_i) & ~clear_mask;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= IDLE;
      cur_floor_q    <= 3'd0;
      dir_up_q       <= 1'b1;
      pending_q      <= '0;
      move_cnt_q     <= '0;
      door_cnt_q     <= '0;
      served_q       <= 1'b0;
      served_floor_q <= 3'd0;
    end else begin
      pending_q <= pending_d;
      served_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          dir_up_q <= dir_eff;
          if (at_cur) begin
            state_q        <= DOOR;
            door_cnt_q     <= '0;
            served_q       <= 1'b1;
            served_floor_q <= cur_floor_q;
          end else if (ahead_eff) begin
            state_q    <= MOVE;
            move_cnt_q <= '0;
          end else if (behind_eff) begin
            dir_up_q   <= ~dir_eff;
            state_q    <= MOVE;
            move_cnt_q <= '0;
          end
        end
        MOVE: begin
          if (move_cnt_q == MOVE_TC) begin
            move_cnt_q  <= '0;
            cur_floor_q <= next_floor;
            if (at_next) begin
              state_q        <= DOOR;
              door_cnt_q     <= '0;
              served_q       <= 1'b1;
              served_floor_q <= next_floor;
            end else if (!ahead_next) begin
              state_q <= IDLE;
            end
          end else begin
            move_cnt_q <= move_cnt_q + 1'b1;
          end
        end
        DOOR: begin
          if (door_cnt_q == DOOR_TC) begin
            move_cnt_q <= '0;
            if (ahead_eff) begin
              dir_up_q <= dir_eff;
              state_q  <= MOVE;
            end else if (behind_eff) begin
              dir_up_q <= ~dir_eff;
              state_q  <= MOVE;
            end else begin
              dir_up_q <= dir_eff;
              state_q  <= IDLE;
            end
          end else begin
            door_cnt_q <= door_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cur_floor_o    = cur_floor_q;
  assign dir_up_o       = dir_up_q;
  assign moving_o       = (state_q == MOVE);
  assign door_open_o    = (state_q == DOOR);
  assign pending_o      = pending_q;
  assign served_o       = served_q;
  assign served_floor_o = served_floor_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: table-driven sweeps from reset plus
// hand sequences for timing, reversal, held buttons and mid-travel reset.
module tb_elevator_request_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [4:0] buttons_i = '0;
  logic [2:0] cur_floor_o;
  logic       dir_up_o, moving_o, door_open_o, served_o;
  logic [4:0] pending_o;
  logic [2:0] served_floor_o;

  elevator_request_scheduler #(.FLOORS(5), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .buttons_i(buttons_i),
    .cur_floor_o(cur_floor_o), .dir_up_o(dir_up_o), .moving_o(moving_o),
    .door_open_o(door_open_o), .pending_o(pending_o), .served_o(served_o),
    .served_floor_o(served_floor_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int served_cnt = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every served pulse must match the next expected floor.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      check("move_door_exclusive", int'(moving_o & door_open_o), 0);
      if (served_o) begin
        served_cnt++;
        check("door_open_at_served", int'(door_open_o), 1);
        if (exp_q.size() == 0) check("unexpected_served_floor", int'(served_floor_o), 99);
        else check("served_floor", int'(served_floor_o), int'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic [4:0]      btn;
    int              n;
    logic [4:0][2:0] seq;
    logic [2:0]      fl;
    logic            dir;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] btn, input int n, input logic [2:0] s0,
                              input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] s3,
                              input logic [2:0] s4, input logic [2:0] fl, input logic dir);
    vec_t v;
    v.btn = btn; v.n = n; v.fl = fl; v.dir = dir;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    return v;
  endfunction

  task automatic do_reset();
    rst_n_i = 1'b0;
    buttons_i = '0;
    repeat (2) @(negedge clk_i);
    exp_q.delete();
    served_cnt = 0;
    rst_n_i = 1'b1;
  endtask

  task automatic press(input logic [4:0] b);
    buttons_i = b;
    @(negedge clk_i);
    buttons_i = '0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (!moving_o && !door_open_o && pending_o == 5'd0) begin
        ok = 1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = mk(5'b00001, 1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    vecs[1] = mk(5'b10000, 1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 1'b0);
    vecs[2] = mk(5'b11111, 5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 1'b0);
    vecs[3] = mk(5'b00100, 1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 1'b1);
    vecs[4] = mk(5'b01010, 2, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0, 3'd3, 1'b1);

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk_i);
    check("rst_cur_floor", int'(cur_floor_o), 0);
    check("rst_dir_up", int'(dir_up_o), 1);
    check("rst_moving", int'(moving_o), 0);
    check("rst_door_open", int'(door_open_o), 0);
    check("rst_pending", int'(pending_o), 0);
    check("rst_served", int'(served_o), 0);
    check("rst_served_floor", int'(served_floor_o), 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].seq[k]);
      press(vecs[v].btn);
      wait_idle("vec_idle_timeout");
      check("vec_final_floor", int'(cur_floor_o), int'(vecs[v].fl));
      check("vec_final_dir", int'(dir_up_o), int'(vecs[v].dir));
      check("vec_served_count", served_cnt, vecs[v].n);
      check("vec_queue_empty", exp_q.size(), 0);
    end

    // Travel timing 0 -> 4.
    begin
      int j, d;
      do_reset();
      exp_q.push_back(3'd4);
      press(5'b10000);
      check("trav_pending_latched", int'(pending_o), 5'b10000);
      check("trav_not_yet_moving", int'(moving_o), 0);
      j = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_i);
        if (door_open_o) break;
        if (moving_o) begin
          check("trav_cur_floor", int'(cur_floor_o), j / 4);
          j++;
        end
      end
      check("trav_move_cycles", j, 16);
      check("trav_door_floor", int'(cur_floor_o), 4);
      d = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_i);
        if (!door_open_o) break;
        d++;
      end
      check("trav_door_cycles", d, 3);
      check("trav_dir_forced_down", int'(dir_up_o), 0);
      check("trav_idle", int'(moving_o), 0);
      check("trav_served_count", served_cnt, 1);
    end

    // Reversal: going up past 2 with a new request at 0.
    begin
      bit seen;
      do_reset();
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd0);
      press(5'b10000);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_i);
        if (moving_o && cur_floor_o == 3'd2) begin seen = 1; break; end
      end
      check("rev_reached_2", int'(seen), 1);
      press(5'b00001);
      wait_idle("rev_idle_timeout");
      check("rev_final_floor", int'(cur_floor_o), 0);
      check("rev_final_dir", int'(dir_up_o), 1);
      check("rev_served_count", served_cnt, 2);
    end

    // Held button at the current floor during the dwell.
    begin
      bit seen;
      int d, reopen;
      do_reset();
      exp_q.push_back(3'd0);
      buttons_i = 5'b00001;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_i);
        if (door_open_o) begin seen = 1; break; end
      end
      check("hold_door_opened", int'(seen), 1);
      d = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_i);
        if (!door_open_o) break;
        d++;
      end
      buttons_i = '0;
      check("hold_door_cycles", d, 3);
      check("hold_pending_exit", int'(pending_o), 0);
      reopen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk_i);
        if (door_open_o || moving_o) reopen++;
      end
      check("hold_no_reopen", reopen, 0);
      check("hold_served_count", served_cnt, 1);
    end

    // Reset mid-travel at floor 2.
    begin
      bit seen;
      int moved;
      do_reset();
      press(5'b10000);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_i);
        if (moving_o && cur_floor_o == 3'd2) begin seen = 1; break; end
      end
      check("rst_mid_reached_2", int'(seen), 1);
      #2 rst_n_i = 1'b0;
      #1;
      check("rst_mid_cur_floor", int'(cur_floor_o), 0);
      check("rst_mid_pending", int'(pending_o), 0);
      check("rst_mid_moving", int'(moving_o), 0);
      check("rst_mid_dir", int'(dir_up_o), 1);
      @(negedge clk_i);
      exp_q.delete();
      rst_n_i = 1'b1;
      moved = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_i);
        if (moving_o || door_open_o || cur_floor_o != 3'd0) moved++;
      end
      check("rst_mid_stays_idle", moved, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
